// File: rtl/epu_pkg.sv
// Shared types for the EPU layer sequencer: one-hot bus modes, descriptor layout, FSM states.
package epu_pkg;

  localparam int unsigned MODE_W = 4;
  localparam int unsigned DESC_W = 32;

  localparam logic [MODE_W-1:0] IDLE_MODE     = 4'b0001;
  localparam logic [MODE_W-1:0] CONV_3x3_MODE = 4'b0010;
  localparam logic [MODE_W-1:0] CONV_1x1_MODE = 4'b0100;
  localparam logic [MODE_W-1:0] MAX_POOL_MODE = 4'b1000;

  typedef enum logic [1:0] {
    OP_CONV_3X3 = 2'd0,
    OP_CONV_1X1 = 2'd1,
    OP_MAX_POOL = 2'd2,
    OP_ILLEGAL  = 2'd3
  } op_e;

  typedef struct packed {
    logic [28:0] reserved;
    logic        last;
    op_e         op;
  } desc_t;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_SWITCH,
    S_START, S_RUN, S_NEXT, S_DONE, S_ERR
  } state_e;

  function automatic logic [MODE_W-1:0] op_to_mode(input op_e op);
    case (op)
      OP_CONV_3X3: op_to_mode = CONV_3x3_MODE;
      OP_CONV_1X1: op_to_mode = CONV_1x1_MODE;
      OP_MAX_POOL: op_to_mode = MAX_POOL_MODE;
      default:     op_to_mode = IDLE_MODE;
    endcase
  endfunction

endpackage

// File: rtl/epu_unit_timeout.sv
// Per-layer RUN watchdog: counts enabled cycles since clear, flags the last allowed cycle.
module epu_unit_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired_c
);

  localparam int unsigned CNT_W = 16;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Fires during the TIMEOUT_CYCLES-th enabled cycle so the FSM leaves right after it.
  assign o_expired_c = (TIMEOUT_CYCLES != 0) && i_en &&
                       ((17'(r_cnt) + 17'd1) == 17'(TIMEOUT_CYCLES));

endmodule

// File: rtl/epu_layer_sequencer.sv
// Walks a descriptor list in SRAM, steering the bus-switcher mode and starting one compute unit per layer.
module epu_layer_sequencer
  import epu_pkg::*;
#(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned MAX_LAYERS     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        layer_idx,
  output logic              desc_cs,
  output logic              desc_oe,
  output logic [ADDR_W-1:0] desc_addr,
  input  logic [31:0]       desc_rdata,
  output logic [3:0]        mode,
  output logic              conv_3x3_start,
  output logic              conv_1x1_start,
  output logic              maxpool_start,
  input  logic              conv_3x3_done,
  input  logic              conv_1x1_done,
  input  logic              maxpool_done
);

  state_e            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_layer_idx;
  logic [3:0]        r_mode;
  logic              r_busy, r_done, r_error, r_cs, r_oe;
  logic              r_c3_start, r_c1_start, r_mp_start;
  op_e               r_op;
  logic              r_last;

  desc_t             w_desc;
  logic              w_unused_rsvd;
  logic              w_sel_done;
  logic              w_expired;
  logic [8:0]        w_idx_inc;
  logic [ADDR_W-1:0] w_ptr_inc;

  assign w_desc        = desc_t'(desc_rdata);
  assign w_unused_rsvd = ^w_desc.reserved;
  assign w_sel_done    = |(r_mode[3:1] & {maxpool_done, conv_1x1_done, conv_3x3_done});
  assign w_idx_inc     = {1'b0, r_layer_idx} + 9'd1;
  assign w_ptr_inc     = r_ptr + ADDR_W'(1);

  epu_unit_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (r_state == S_START),
    .i_en        (r_state == S_RUN),
    .o_expired_c (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_addr      <= '0;
      r_layer_idx <= '0;
      r_mode      <= IDLE_MODE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_cs        <= 1'b0;
      r_oe        <= 1'b0;
      r_c3_start  <= 1'b0;
      r_c1_start  <= 1'b0;
      r_mp_start  <= 1'b0;
      r_op        <= OP_CONV_3X3;
      r_last      <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_cs       <= 1'b0;
      r_oe       <= 1'b0;
      r_c3_start <= 1'b0;
      r_c1_start <= 1'b0;
      r_mp_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ptr       <= base_addr;
            r_addr      <= base_addr;
            r_error     <= 1'b0;
            r_layer_idx <= '0;
            r_busy      <= 1'b1;
            r_cs        <= 1'b1;
            r_oe        <= 1'b1;
            r_state     <= S_FETCH;
          end
        end
        S_FETCH: r_state <= S_WAIT;
        S_WAIT: begin
          r_op    <= w_desc.op;
          r_last  <= w_desc.last;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          if (r_op == OP_ILLEGAL) begin
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_mode  <= IDLE_MODE;
            r_state <= S_ERR;
          end else begin
            r_mode  <= op_to_mode(r_op);
            r_state <= S_SWITCH;
          end
        end
        S_SWITCH: begin
          r_c3_start <= r_mode[1];
          r_c1_start <= r_mode[2];
          r_mp_start <= r_mode[3];
          r_state    <= S_START;
        end
        S_START: r_state <= S_RUN;
        // Unit done wins over a watchdog expiry landing in the same cycle.
        S_RUN: begin
          if (w_sel_done) begin
            r_state <= S_NEXT;
          end else if (w_expired) begin
            r_error <= 1'b1;
            r_done  <= 1'b1;
            r_mode  <= IDLE_MODE;
            r_state <= S_ERR;
          end
        end
        S_NEXT: begin
          r_mode <= IDLE_MODE;
          if (r_last) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_ptr       <= w_ptr_inc;
            r_layer_idx <= (r_layer_idx == 8'hFF) ? 8'hFF : w_idx_inc[7:0];
            if (32'(w_idx_inc) == MAX_LAYERS) begin
              r_error <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_ERR;
            end else begin
              r_addr  <= w_ptr_inc;
              r_cs    <= 1'b1;
              r_oe    <= 1'b1;
              r_state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_ERR: begin
          r_busy  <= 1'b0;
          r_mode  <= IDLE_MODE;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign error          = r_error;
  assign layer_idx      = r_layer_idx;
  assign desc_cs        = r_cs;
  assign desc_oe        = r_oe;
  assign desc_addr      = r_addr;
  assign mode           = r_mode;
  assign conv_3x3_start = r_c3_start;
  assign conv_1x1_start = r_c1_start;
  assign maxpool_start  = r_mp_start;

endmodule
